mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, SHALL set the maximum number of cycles in REQ state awaiting mem_ack (legal range 1..255).
REQ-002 CLK  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 CLR  in  1  reset, synchronous, active-low.
REQ-004 mar_q  in  16  access address, sourced from the register block's MAR.
REQ-005 mdr_q  in  16  write data, sourced from the register block's MDR.
REQ-006 rd_req / wr_req / if_req  in  1 each  data read / data write / instruction fetch request.
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 done  out  1  one-cycle completion strobe.
REQ-009 err  out  1  one-cycle timeout strobe, coincident with done.
REQ-010 MMD_out  out  16  read data to the register block's MDR path; zero when not strobed.
REQ-011 MIS_out  out  16  fetched instruction to the register block's ISR path; zero when not strobed.
REQ-012 mem_req, mem_we  out  1 each  memory request / write enable.
REQ-013 mem_addr, mem_wdata  out  16 each  memory address / write data.
REQ-014 mem_rdata  in  16; mem_ack  in  1  memory read data / acknowledge.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-016 In IDLE, on a cycle where any request is high, the block SHALL latch mar_q, mdr_q, and the operation, then enter REQ on the next edge.
REQ-017 Simultaneous requests SHALL be resolved with the priority wr_req > rd_req > if_req; lower-priority requests SHALL be dropped, not queued.
REQ-018 Requests SHALL be ignored while busy=1.
REQ-019 In REQ: mem_req=1, mem_addr=latched address, and mem_we=1 only for writes. mem_wdata SHALL equal latched data for writes and 0 otherwise.
REQ-020 In REQ, when mem_ack=1 is sampled, mem_rdata SHALL be captured for reads and fetches, and the FSM SHALL enter DONE.
REQ-021 Wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack; on reaching TIMEOUT_CYC, the FSM SHALL enter DONE with the error flag set.
REQ-022 If ack and timeout occur in the same cycle, ack SHALL win and no error is raised.
REQ-023 In DONE: mem_req=0 and done=1 for exactly one cycle.
REQ-024 In DONE, err=1 only if the transaction timed out.
REQ-025 In DONE, MMD_out=captured data for a successful read, and MIS_out=captured data for a successful fetch; both outputs SHALL be 0 for writes and errors.
REQ-026 DONE SHALL always return to IDLE on the next edge.
REQ-027 mem_ack sampled in IDLE or DONE SHALL be ignored.
REQ-028 Latency with zero-wait memory: request at edge N, mem_req high in cycle N+1, done in cycle N+2, and the next request accepted in cycle N+3.
REQ-029 MMD_out and MIS_out SHALL be registered outputs and SHALL be zero in every cycle except the DONE cycle.

Reset
REQ-030 CLR=0 sampled at an edge SHALL force IDLE and clear the wait counter, latched address, latched data, and captured data.
REQ-031 After reset, all outputs SHALL be 0.
REQ-032 Reset asserted during REQ or DONE SHALL abort the transaction: mem_req SHALL be 0 from the next cycle, and no done or err SHALL be issued.

Structure
REQ-033 Shared package mem_ctrl_pkg SHALL hold the state encoding (IDLE, REQ, DONE), the operation encoding (OP_RD, OP_WR, OP_IF), and the TIMEOUT_CYC default.
REQ-034 The wait counter SHALL be a sub-module, wait_timer, with ports clear, enable, and expired (8-bit counter).
REQ-035 The memory model used for test SHALL be bench-only; the block SHALL contain no memory array.

Verification
REQ-036 Reset held, then released, with no requests -> all outputs 0 and busy=0.
REQ-037 mar_q=0x1000 with rd_req pulse, memory returns 0x2000 with ack after 2 wait cycles -> mem_addr=0x1000 and mem_we=0 during REQ; one done cycle with MMD_out=0x2000 and MIS_out=0; MMD_out=0 on the following cycle.
REQ-038 mar_q=0x0040, mdr_q=0xABCD, with wr_req and rd_req and if_req all high in the same cycle -> write only: mem_we=1 and mem_wdata=0xABCD; at done, MMD_out=0 and MIS_out=0; no second transaction follows.
REQ-039 if_req with mar_q=0x0002, zero-wait ack, mem_rdata=0x4000 -> MIS_out=0x4000 exactly at cycle N+2, and a new if_req is accepted at N+3.
REQ-040 rd_req with mem_ack never asserted, TIMEOUT_CYC=15 -> 15 REQ cycles, then done=1 with err=1 and MMD_out=0.
REQ-040a Repeat of REQ-040 with ack asserted on the 15th REQ cycle -> err=0 and data is delivered.
REQ-041 CLR dropped to 0 in the 2nd REQ cycle of a read -> mem_req=0 on the next cycle, busy=0, and no done strobe before the next request.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: FSM states, operation codes,
// the default timeout and the request priority pick.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_RD = 2'd0,
        OP_WR = 2'd1,
        OP_IF = 2'd2
    } op_t;

    localparam int TIMEOUT_CYC_DEF = 15;

    // Write beats read beats fetch; losers are simply dropped.
    function automatic op_t pick_op(input logic wr, input logic rd);
        if (wr)
            return OP_WR;
        else if (rd)
            return OP_RD;
        else
            return OP_IF;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Register-block and memory-side signals of the memory controller.
// The slave modport is the controller's view; master is the environment's.
interface mem_ctrl_if;
    logic [15:0] mar_q;
    logic [15:0] mdr_q;
    logic        rd_req;
    logic        wr_req;
    logic        if_req;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] MMD_out;
    logic [15:0] MIS_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  mar_q, mdr_q, rd_req, wr_req, if_req, mem_rdata, mem_ack,
        output busy, done, err, MMD_out, MIS_out,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output mar_q, mdr_q, rd_req, wr_req, if_req, mem_rdata, mem_ack,
        input  busy, done, err, MMD_out, MIS_out,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_ctrl_wait_timer.sv
// 8-bit wait counter; expired flags the cycle whose increment would reach LIMIT.
module wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LIM = 8'(LIMIT);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign count_d = count_q + 8'd1;
    assign expired = enable && (count_d == LIM);

    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= 8'd0;
        else if (clear)
            count_q <= 8'd0;
        else if (enable)
            count_q <= count_d;
    end
endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding memory access controller: IDLE -> REQ -> DONE, with a
// wait timeout. All outputs are registered; requests are ignored while busy.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic      CLK,
    input  logic      CLR,
    mem_ctrl_if.slave bus
);
    state_t      state_q;
    op_t         op_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] mmd_q;
    logic [15:0] mis_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;

    logic any_req;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;
    op_t  op_d;

    assign any_req    = bus.wr_req | bus.rd_req | bus.if_req;
    assign op_d       = pick_op(bus.wr_req, bus.rd_req);
    assign tmr_clear  = (state_q != REQ);
    assign tmr_enable = (state_q == REQ) && !bus.mem_ack;

    wait_timer #(.LIMIT(TIMEOUT_CYC)) u_wait_timer (
        .clk     (CLK),
        .rst_n   (CLR),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // mem_addr_q / mem_wdata_q double as the latched address and data.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mmd_q       <= 16'd0;
            mis_q       <= 16'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    mmd_q  <= 16'd0;
                    mis_q  <= 16'd0;
                    if (any_req) begin
                        state_q     <= REQ;
                        op_q        <= op_d;
                        busy_q      <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (op_d == OP_WR);
                        mem_addr_q  <= bus.mar_q;
                        mem_wdata_q <= (op_d == OP_WR) ? bus.mdr_q : 16'd0;
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (bus.mem_ack || tmr_expired) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        err_q       <= !bus.mem_ack;
                        mmd_q       <= (bus.mem_ack && op_q == OP_RD) ? bus.mem_rdata : 16'd0;
                        mis_q       <= (bus.mem_ack && op_q == OP_IF) ? bus.mem_rdata : 16'd0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 16'd0;
                        mem_wdata_q <= 16'd0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    mmd_q   <= 16'd0;
                    mis_q   <= 16'd0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.MMD_out   = mmd_q;
    assign bus.MIS_out   = mis_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
